// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scanner: one digit per REFRESH_DIV-cycle slot,
// with a blanked guard interval at the start of each slot to suppress ghosting.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_CYC   = 2,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   Anode,
    output logic [7:0]              Cathode,
    output logic                    frame_done
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [NUM_DIGITS-1:0][3:0] val_q;
    logic [NUM_DIGITS-1:0]      blank_q;
    logic [NUM_DIGITS-1:0]      dp_q;
    logic [CNT_W-1:0]           cnt;
    logic [IDX_W-1:0]           idx;
    logic                       last_cnt;
    logic                       last_idx;

    // Active-high segment pattern {g,f,e,d,c,b,a}
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'h0: decode = 7'h3F;
            4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;
            4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;
            4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;
            4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;
            4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;
            default: decode = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q   <= '0;
            blank_q <= '0;
            dp_q    <= '0;
        end else if (load) begin
            val_q   <= value;
            blank_q <= blank_mask;
            dp_q    <= dp_mask;
        end
    end

    assign last_cnt = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign last_idx = (idx == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (last_cnt) begin
            cnt <= '0;
            idx <= last_idx ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    logic [NUM_DIGITS-1:0] lz_vec;
    logic                  zero_run;
    logic                  guard;
    logic                  dark;
    logic [NUM_DIGITS-1:0] an_on;
    logic [7:0]            seg_on;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic [7:0]            cat_nxt;
    logic                  fd_nxt;

    always_comb begin
        // lz_vec[i] = digit i and all higher digits are zero
        zero_run = 1'b1;
        lz_vec   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run  = zero_run & (val_q[i] == 4'h0);
            lz_vec[i] = zero_run;
        end
        guard  = (int'(cnt) < GUARD_CYC);
        dark   = blank_q[idx] | (lz_en & (idx != '0) & lz_vec[idx]);
        an_on  = '0;
        seg_on = '0;
        if (!guard) begin
            an_on[idx] = 1'b1;
            if (!dark) seg_on = {dp_q[idx], decode(val_q[idx])};
        end
        an_nxt  = ACTIVE_LOW ? ~an_on : an_on;
        cat_nxt = ACTIVE_LOW ? ~seg_on : seg_on;
        fd_nxt  = last_cnt & last_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Anode      <= ACTIVE_LOW ? '1 : '0;
            Cathode    <= ACTIVE_LOW ? 8'hFF : 8'h00;
            frame_done <= 1'b0;
        end else begin
            Anode      <= an_nxt;
            Cathode    <= cat_nxt;
            frame_done <= fd_nxt;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random load/reset traffic,
// checked against a slot-arithmetic reference model.
module tb_seg7_scan_ctrl;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int GC = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic [3:0]  blank_mask;
    logic [3:0]  dp_mask;
    logic        lz_en;
    logic [3:0]  Anode;
    logic [7:0]  Cathode;
    logic        frame_done;

    seg7_scan_ctrl #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYC(GC), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .blank_mask(blank_mask), .dp_mask(dp_mask), .lz_en(lz_en),
        .Anode(Anode), .Cathode(Cathode), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int fd_cnt = 0;

    // Active-low cathode codes for hex 0..F with dp off
    logic [7:0] al_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: n = clock edges since reset released
    logic [15:0] m_val;
    logic [3:0]  m_blank, m_dp;
    int          n;
    logic [3:0]  e_an;
    logic [7:0]  e_cat;
    logic        e_fd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        int pos, slot;
        logic [3:0] nib, one_hot;
        bit dark;
        if (rst) begin
            m_val = '0; m_blank = '0; m_dp = '0; n = 0;
            e_an = 4'hF; e_cat = 8'hFF; e_fd = 1'b0;
        end else begin
            pos  = n % RD;
            slot = (n / RD) % ND;
            e_fd = ((n % (ND * RD)) == ND * RD - 1);
            nib  = m_val[4*slot +: 4];
            dark = m_blank[slot] || (lz_en && slot != 0 && (m_val >> (4 * slot)) == 16'h0);
            if (pos < GC) begin
                e_an = 4'hF; e_cat = 8'hFF;
            end else begin
                one_hot = 4'b0001 << slot;
                e_an  = ~one_hot;
                e_cat = dark ? 8'hFF : (m_dp[slot] ? (al_tab[nib] & 8'h7F) : al_tab[nib]);
            end
            if (load) begin
                m_val = value; m_blank = blank_mask; m_dp = dp_mask;
            end
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        chk("anode", 32'(Anode), 32'(e_an));
        chk("cathode", 32'(Cathode), 32'(e_cat));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        fd_cnt += int'(frame_done);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] b, input logic [3:0] d);
        value = v; blank_mask = b; dp_mask = d; load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cyc();
    endtask

    initial begin
        // Reset held with a load pending: shadow must stay clear
        rst = 1'b1; load = 1'b1; value = 16'hFFFF; blank_mask = 4'hF; dp_mask = 4'hF; lz_en = 1'b0;
        run(3);
        chk("rst_anode", 32'(Anode), 32'h0000_000F);
        chk("rst_cathode", 32'(Cathode), 32'h0000_00FF);
        rst = 1'b0; load = 1'b0;
        run(8);

        do_load(16'h12A8, 4'h0, 4'h0);
        fd_cnt = 0;
        run(64);
        chk("fd_count", 32'(fd_cnt), 32'd4);

        lz_en = 1'b1;
        do_load(16'h0030, 4'h0, 4'h0);
        run(20);
        do_load(16'h0000, 4'h0, 4'h0);
        run(20);
        lz_en = 1'b0;
        do_load(16'h0000, 4'b0100, 4'b0001);
        run(20);

        // Mid-slot load when the slot counter sits at 2
        while ((n % RD) != 2) cyc();
        do_load(16'hFEDC, 4'h0, 4'h0);
        run(10);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        run(12);

        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            lz_en = ($urandom_range(0, 15) == 0) ? ~lz_en : lz_en;
            if ($urandom_range(0, 7) == 0) begin
                value = 16'($urandom);
                if ($urandom_range(0, 1) == 0) value = value >> (4 * $urandom_range(1, 3));
                blank_mask = 4'($urandom);
                dp_mask    = 4'($urandom);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            cyc();
        end
        rst = 1'b0; load = 1'b0;
        run(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
